// File: rtl/rob_retire_pkg.sv
// rob_retire_pkg: shared ROB/LSQ/map-table types and retire FSM states.
package rob_retire_pkg;
  localparam int ROB_SIZE = 16;
  localparam int LSQ_SIZE = 8;
  localparam int NUMBER_OF_REGISTERS = 32;
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int TAG_W = $clog2(ROB_SIZE + 1);
  typedef logic [TAG_W-1:0] RobSize;
  typedef enum logic [1:0] {RUN, STORE_WAIT, HALTED} retire_state_t;
  typedef struct packed {
    logic memtoreg;
    logic memwr;
    logic cjump;
    logic ecall;
    logic unsupported;
  } control_bits;
  typedef struct packed {
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] value;
    control_bits ctrl_bits;
  } rob_entry;
  typedef struct packed {
    RobSize tag;
  } map_table_entry;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } lsq_entry;
  typedef struct packed {
    logic [4:0]  regstr;
    logic [31:0] value;
  } Victim;
  // Tags are 1-based so that 0 can mean "no producer".
  function automatic RobSize idx_to_tag(logic [IDX_W-1:0] idx);
    return RobSize'(idx) + RobSize'(1);
  endfunction
endpackage

// File: rtl/rob_retire_if.sv
// rob_retire_if: ROB/map-table view plus retire outputs toward RF, LSQ and memory.
interface rob_retire_if;
  import rob_retire_pkg::*;
  int rob_head;
  int rob_count;
  rob_entry [ROB_SIZE-1:0] rob;
  map_table_entry [NUMBER_OF_REGISTERS-1:0] map_table;
  logic store_ack;
  logic rob_pop;
  logic lsq_pop;
  logic store_req;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic mt_clear;
  logic [4:0] mt_clear_reg;
  Victim victim;
  logic halt;
  logic [31:0] retired_count;
  modport master (
    input  rob_head, rob_count, rob, map_table, store_ack,
    output rob_pop, lsq_pop, store_req, rf_we, rf_waddr, rf_wdata,
           mt_clear, mt_clear_reg, victim, halt, retired_count
  );
  modport slave (
    output rob_head, rob_count, rob, map_table, store_ack,
    input  rob_pop, lsq_pop, store_req, rf_we, rf_waddr, rf_wdata,
           mt_clear, mt_clear_reg, victim, halt, retired_count
  );
endinterface

// File: rtl/rob_retire_store_handshake.sv
// retire_store_handshake: retire state machine; holds a registered store_req until ack.
module retire_store_handshake
  import rob_retire_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start_store,
  input  logic          start_halt,
  input  logic          store_ack,
  output retire_state_t state,
  output logic          store_req,
  output logic          store_done
);
  retire_state_t next;
  always_comb begin
    next = state;
    store_done = 1'b0;
    case (state)
      RUN:        next = start_store ? STORE_WAIT : start_halt ? HALTED : RUN;
      STORE_WAIT: begin
        store_done = store_ack;
        next = store_ack ? RUN : STORE_WAIT;
      end
      default:    next = HALTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      store_req <= 1'b0;
    end else begin
      state <= next;
      store_req <= next == STORE_WAIT;
    end
  end
endmodule

// File: rtl/rob_retire.sv
// rob_retire: in-order ROB head commit with RF write, map clear, store handshake and ecall halt.
module rob_retire
  import rob_retire_pkg::*;
(
  input logic clk,
  input logic reset,
  rob_retire_if.master bus
);
  logic [IDX_W-1:0] idx;
  rob_entry h;
  retire_state_t state;
  logic retire_ok, retire_now, writes, store_done, store_req;
  assign idx = IDX_W'(bus.rob_head % ROB_SIZE);
  assign h = bus.rob[idx];
  assign retire_ok = state == RUN && bus.rob_count > 0 && h.ready;
  assign retire_now = retire_ok && !h.ctrl_bits.memwr;
  assign writes = retire_now && h.rd != 5'd0 && !h.ctrl_bits.unsupported
                  && !h.ctrl_bits.ecall && !h.ctrl_bits.cjump;
  assign bus.rob_pop = retire_now || store_done;
  assign bus.lsq_pop = (retire_now && h.ctrl_bits.memtoreg) || store_done;
  assign bus.store_req = store_req;
  retire_store_handshake u_hs (
    .clk(clk),
    .reset(reset),
    .start_store(retire_ok && h.ctrl_bits.memwr),
    .start_halt(retire_now && h.ctrl_bits.ecall),
    .store_ack(bus.store_ack),
    .state(state),
    .store_req(store_req),
    .store_done(store_done)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.mt_clear <= 1'b0;
      bus.mt_clear_reg <= '0;
      bus.victim <= '0;
      bus.halt <= 1'b0;
      bus.retired_count <= '0;
    end else begin
      bus.rf_we <= writes;
      // A younger rename of rd keeps its mapping; only our own tag is cleared.
      bus.mt_clear <= writes && bus.map_table[h.rd].tag == idx_to_tag(idx);
      if (writes) begin
        bus.rf_waddr <= h.rd;
        bus.rf_wdata <= h.value;
        bus.mt_clear_reg <= h.rd;
      end
      if (bus.rob_pop) bus.victim <= writes ? {h.rd, h.value} : '0;
      bus.retired_count <= bus.retired_count + 32'(bus.rob_pop);
      bus.halt <= bus.halt | (retire_now && h.ctrl_bits.ecall);
    end
  end
endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed scenario tasks for the ROB retire stage.
module tb_rob_retire;
  import rob_retire_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cmps = 0;
  int errs = 0;
  rob_retire_if bus();
  rob_retire dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  localparam control_bits CB_NONE = '0;
  localparam control_bits CB_LOAD = '{memtoreg: 1'b1, default: 1'b0};
  localparam control_bits CB_STORE = '{memwr: 1'b1, default: 1'b0};
  localparam control_bits CB_ECALL = '{ecall: 1'b1, default: 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic rdy, input logic [4:0] rd,
                      input logic [31:0] val, input control_bits cb);
    bus.rob[i].ready = rdy;
    bus.rob[i].rd = rd;
    bus.rob[i].value = val;
    bus.rob[i].ctrl_bits = cb;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    if (bus.rf_we !== 1'b0) begin $display("FAIL reset rf_we got %0h want 0", bus.rf_we); errs++; end cmps++;
    if (bus.rf_waddr !== 5'd0) begin $display("FAIL reset rf_waddr got %0h want 0", bus.rf_waddr); errs++; end cmps++;
    if (bus.rf_wdata !== 32'd0) begin $display("FAIL reset rf_wdata got %0h want 0", bus.rf_wdata); errs++; end cmps++;
    if (bus.mt_clear !== 1'b0) begin $display("FAIL reset mt_clear got %0h want 0", bus.mt_clear); errs++; end cmps++;
    if (bus.victim !== 37'd0) begin $display("FAIL reset victim got %0h want 0", bus.victim); errs++; end cmps++;
    if (bus.halt !== 1'b0) begin $display("FAIL reset halt got %0h want 0", bus.halt); errs++; end cmps++;
    if (bus.retired_count !== 32'd0) begin $display("FAIL reset count got %0d want 0", bus.retired_count); errs++; end cmps++;
    if (bus.store_req !== 1'b0) begin $display("FAIL reset store_req got %0h want 0", bus.store_req); errs++; end cmps++;
    if (bus.rob_pop !== 1'b0) begin $display("FAIL reset rob_pop got %0h want 0", bus.rob_pop); errs++; end cmps++;
    reset = 1'b1;
  endtask

  task automatic test_add_clear();
    load(2, 1'b1, 5'd5, 32'h2A, CB_NONE);
    bus.map_table[5].tag = RobSize'(3);
    bus.rob_head = 2;
    bus.rob_count = 1;
    #1;
    if (bus.rob_pop !== 1'b1) begin $display("FAIL add rob_pop got %0h want 1", bus.rob_pop); errs++; end cmps++;
    if (bus.lsq_pop !== 1'b0) begin $display("FAIL add lsq_pop got %0h want 0", bus.lsq_pop); errs++; end cmps++;
    tick();
    bus.rob_count = 0;
    if (bus.rf_we !== 1'b1) begin $display("FAIL add rf_we got %0h want 1", bus.rf_we); errs++; end cmps++;
    if (bus.rf_waddr !== 5'd5) begin $display("FAIL add rf_waddr got %0h want 5", bus.rf_waddr); errs++; end cmps++;
    if (bus.rf_wdata !== 32'h2A) begin $display("FAIL add rf_wdata got %0h want 2a", bus.rf_wdata); errs++; end cmps++;
    if (bus.mt_clear !== 1'b1) begin $display("FAIL add mt_clear got %0h want 1", bus.mt_clear); errs++; end cmps++;
    if (bus.mt_clear_reg !== 5'd5) begin $display("FAIL add mt_clear_reg got %0h want 5", bus.mt_clear_reg); errs++; end cmps++;
    if (bus.victim !== {5'd5, 32'h2A}) begin $display("FAIL add victim got %0h want %0h", bus.victim, {5'd5, 32'h2A}); errs++; end cmps++;
    if (bus.retired_count !== 32'd1) begin $display("FAIL add count got %0d want 1", bus.retired_count); errs++; end cmps++;
    #1;
    if (bus.rob_pop !== 1'b0) begin $display("FAIL add_empty rob_pop got %0h want 0", bus.rob_pop); errs++; end cmps++;
  endtask

  task automatic test_rd0();
    load(3, 1'b1, 5'd0, 32'h55, CB_NONE);
    bus.rob_head = 3;
    bus.rob_count = 1;
    #1;
    if (bus.rob_pop !== 1'b1) begin $display("FAIL rd0 rob_pop got %0h want 1", bus.rob_pop); errs++; end cmps++;
    tick();
    bus.rob_count = 0;
    if (bus.rf_we !== 1'b0) begin $display("FAIL rd0 rf_we got %0h want 0", bus.rf_we); errs++; end cmps++;
    if (bus.mt_clear !== 1'b0) begin $display("FAIL rd0 mt_clear got %0h want 0", bus.mt_clear); errs++; end cmps++;
    if (bus.victim !== 37'd0) begin $display("FAIL rd0 victim got %0h want 0", bus.victim); errs++; end cmps++;
    if (bus.retired_count !== 32'd2) begin $display("FAIL rd0 count got %0d want 2", bus.retired_count); errs++; end cmps++;
  endtask

  task automatic test_younger_rename();
    load(2, 1'b1, 5'd5, 32'h2A, CB_LOAD);
    bus.map_table[5].tag = RobSize'(7);
    bus.rob_head = 2;
    bus.rob_count = 1;
    #1;
    if (bus.rob_pop !== 1'b1) begin $display("FAIL younger rob_pop got %0h want 1", bus.rob_pop); errs++; end cmps++;
    if (bus.lsq_pop !== 1'b1) begin $display("FAIL younger lsq_pop got %0h want 1", bus.lsq_pop); errs++; end cmps++;
    tick();
    bus.rob_count = 0;
    if (bus.rf_we !== 1'b1) begin $display("FAIL younger rf_we got %0h want 1", bus.rf_we); errs++; end cmps++;
    if (bus.mt_clear !== 1'b0) begin $display("FAIL younger mt_clear got %0h want 0", bus.mt_clear); errs++; end cmps++;
    if (bus.victim !== {5'd5, 32'h2A}) begin $display("FAIL younger victim got %0h want %0h", bus.victim, {5'd5, 32'h2A}); errs++; end cmps++;
    if (bus.retired_count !== 32'd3) begin $display("FAIL younger count got %0d want 3", bus.retired_count); errs++; end cmps++;
  endtask

  task automatic test_not_ready();
    load(3, 1'b0, 5'd6, 32'h77, CB_NONE);
    bus.rob_head = 3;
    bus.rob_count = 1;
    #1;
    if (bus.rob_pop !== 1'b0) begin $display("FAIL notready rob_pop got %0h want 0", bus.rob_pop); errs++; end cmps++;
    tick();
    bus.rob_count = 0;
    if (bus.rf_we !== 1'b0) begin $display("FAIL notready rf_we got %0h want 0", bus.rf_we); errs++; end cmps++;
    if (bus.victim !== {5'd5, 32'h2A}) begin $display("FAIL notready victim got %0h want %0h", bus.victim, {5'd5, 32'h2A}); errs++; end cmps++;
    if (bus.retired_count !== 32'd3) begin $display("FAIL notready count got %0d want 3", bus.retired_count); errs++; end cmps++;
  endtask

  task automatic test_store();
    bus.store_ack = 1'b1;
    tick();
    bus.store_ack = 1'b0;
    if (bus.store_req !== 1'b0) begin $display("FAIL stray_ack store_req got %0h want 0", bus.store_req); errs++; end cmps++;
    if (bus.retired_count !== 32'd3) begin $display("FAIL stray_ack count got %0d want 3", bus.retired_count); errs++; end cmps++;
    load(4, 1'b1, 5'd9, 32'h99, CB_STORE);
    bus.rob_head = 4;
    bus.rob_count = 1;
    #1;
    if (bus.rob_pop !== 1'b0) begin $display("FAIL store_run rob_pop got %0h want 0", bus.rob_pop); errs++; end cmps++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.store_req !== 1'b1) begin $display("FAIL store_wait%0d store_req got %0h want 1", i, bus.store_req); errs++; end cmps++;
      if (bus.rob_pop !== 1'b0) begin $display("FAIL store_wait%0d rob_pop got %0h want 0", i, bus.rob_pop); errs++; end cmps++;
    end
    bus.store_ack = 1'b1;
    #1;
    if (bus.rob_pop !== 1'b1) begin $display("FAIL store_ack rob_pop got %0h want 1", bus.rob_pop); errs++; end cmps++;
    if (bus.lsq_pop !== 1'b1) begin $display("FAIL store_ack lsq_pop got %0h want 1", bus.lsq_pop); errs++; end cmps++;
    tick();
    bus.store_ack = 1'b0;
    bus.rob_count = 0;
    if (bus.store_req !== 1'b0) begin $display("FAIL store_done store_req got %0h want 0", bus.store_req); errs++; end cmps++;
    if (bus.retired_count !== 32'd4) begin $display("FAIL store_done count got %0d want 4", bus.retired_count); errs++; end cmps++;
    if (bus.rf_we !== 1'b0) begin $display("FAIL store_done rf_we got %0h want 0", bus.rf_we); errs++; end cmps++;
    if (bus.victim !== 37'd0) begin $display("FAIL store_done victim got %0h want 0", bus.victim); errs++; end cmps++;
  endtask

  task automatic test_ecall();
    load(4, 1'b1, 5'd0, 32'd0, CB_ECALL);
    load(5, 1'b1, 5'd7, 32'h70, CB_NONE);
    bus.rob_head = 4;
    bus.rob_count = 2;
    #1;
    if (bus.rob_pop !== 1'b1) begin $display("FAIL ecall rob_pop got %0h want 1", bus.rob_pop); errs++; end cmps++;
    tick();
    bus.rob_head = 5;
    bus.rob_count = 1;
    if (bus.halt !== 1'b1) begin $display("FAIL ecall halt got %0h want 1", bus.halt); errs++; end cmps++;
    if (bus.retired_count !== 32'd5) begin $display("FAIL ecall count got %0d want 5", bus.retired_count); errs++; end cmps++;
    if (bus.rf_we !== 1'b0) begin $display("FAIL ecall rf_we got %0h want 0", bus.rf_we); errs++; end cmps++;
    for (int i = 0; i < 3; i++) begin
      bus.store_ack = i[0] ? 1'b0 : 1'b1;
      #1;
      if (bus.rob_pop !== 1'b0) begin $display("FAIL halted%0d rob_pop got %0h want 0", i, bus.rob_pop); errs++; end cmps++;
      tick();
      if (bus.store_req !== 1'b0) begin $display("FAIL halted%0d store_req got %0h want 0", i, bus.store_req); errs++; end cmps++;
    end
    bus.store_ack = 1'b0;
    if (bus.halt !== 1'b1) begin $display("FAIL halted halt got %0h want 1", bus.halt); errs++; end cmps++;
    if (bus.retired_count !== 32'd5) begin $display("FAIL halted count got %0d want 5", bus.retired_count); errs++; end cmps++;
    if (bus.rf_we !== 1'b0) begin $display("FAIL halted rf_we got %0h want 0", bus.rf_we); errs++; end cmps++;
  endtask

  task automatic test_reset_store();
    bus.rob_count = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    if (bus.halt !== 1'b0) begin $display("FAIL rst_halt halt got %0h want 0", bus.halt); errs++; end cmps++;
    load(6, 1'b1, 5'd3, 32'h33, CB_STORE);
    bus.rob_head = 6;
    bus.rob_count = 1;
    tick();
    if (bus.store_req !== 1'b1) begin $display("FAIL rst_store enter store_req got %0h want 1", bus.store_req); errs++; end cmps++;
    reset = 1'b0;
    tick();
    if (bus.store_req !== 1'b0) begin $display("FAIL rst_store store_req got %0h want 0", bus.store_req); errs++; end cmps++;
    if (bus.retired_count !== 32'd0) begin $display("FAIL rst_store count got %0d want 0", bus.retired_count); errs++; end cmps++;
    if (bus.victim !== 37'd0) begin $display("FAIL rst_store victim got %0h want 0", bus.victim); errs++; end cmps++;
    if (bus.rf_wdata !== 32'd0) begin $display("FAIL rst_store rf_wdata got %0h want 0", bus.rf_wdata); errs++; end cmps++;
    reset = 1'b1;
    tick();
    bus.rob_count = 0;
    if (bus.store_req !== 1'b1) begin $display("FAIL rst_store rerun store_req got %0h want 1", bus.store_req); errs++; end cmps++;
  endtask

  initial begin
    bus.rob_head = 0;
    bus.rob_count = 0;
    bus.rob = '0;
    bus.map_table = '0;
    bus.store_ack = 1'b0;
    test_reset();
    test_add_clear();
    test_rd0();
    test_younger_rename();
    test_not_ready();
    test_store();
    test_ecall();
    test_reset_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order commit stage at the ROB head; consumes the entries the dispatch scheduler allocates at the ROB/LSQ tails.
- Writes results to the architectural register file and publishes the Victim (most recently retired reg/value) used by dispatch operand lookup.
- Clears stale map-table entries, pops the ROB and LSQ heads, sequences store commit to data memory via req/ack, and halts on ecall.

Parameters:
ROB_SIZE, 16, ROB entries; tags are 1..ROB_SIZE, with 0 meaning "no tag"
LSQ_SIZE, 8, LSQ entries
NREGS, 32, architectural registers

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
rob_head  in  int  head index (0-based)
rob_count  in  int  valid ROB entries
rob  in  ROB_SIZE x rob_entry  ROB array
map_table  in  NREGS x map_table_entry  current rename map
store_ack  in  1  data memory accepted committed store
rob_pop  out  1  advance ROB head this cycle
lsq_pop  out  1  advance LSQ head this cycle
store_req  out  1  commit store at LSQ head
rf_we  out  1  register file write enable
rf_waddr  out  5  write register
rf_wdata  out  32  write data
mt_clear  out  1  clear map_table[mt_clear_reg]
mt_clear_reg  out  5  register whose mapping is cleared
victim  out  Victim  last retired {regstr, value}
halt  out  1  sticky ecall halt
retired_count  out  32  instructions retired

Behaviour:
- States: RUN, STORE_WAIT, HALTED.
- Reset (reset==0 at posedge): state=RUN. All registered outputs are 0: rf_we, rf_waddr, rf_wdata, mt_clear, mt_clear_reg, victim, halt, retired_count, store_req.
- Reset mid-STORE_WAIT aborts the store; store_req is 0 the next cycle.
- H = rob[rob_head]; retire_ok = state==RUN && rob_count>0 && H.ready.
- rob_pop and lsq_pop are combinational (Mealy). Max one retire per cycle. There is no double-pop because the head advances at the same edge.
- RUN, retire_ok, non-store: rob_pop=1 this cycle.
  - lsq_pop=1 if H.ctrl_bits.memtoreg.
  - Next cycle: rf_we=1 iff H.rd!=0 and not unsupported/ecall/cjump. rf_waddr=H.rd, rf_wdata=H.value.
  - Next cycle: victim={H.rd,H.value} if writing, else {0,0}.
  - Next cycle: retired_count+1, wrapping at 2^32.
  - mt_clear=1 next cycle iff writing and map_table[H.rd].tag == rob_head+1. Not cleared if renamed by a younger instruction.
- RUN, retire_ok, H.ctrl_bits.memwr: no pop; go to STORE_WAIT.
- STORE_WAIT: store_req=1, registered and held until ack. store_ack is sampled only here.
  - On store_ack: rob_pop=1, lsq_pop=1 the same cycle; go to RUN. retired_count+1 next cycle, rf_we=0, victim={0,0}.
- store_ack outside STORE_WAIT is ignored.
- RUN, retire_ok, ecall: rob_pop=1; next state HALTED, halt=1, retired_count+1.
- HALTED: no pops; rf_we=0, mt_clear=0; halt stays 1 until reset.
- Unsupported at head: retires like a non-writing instruction and is counted.
- rob_count==0, or head not ready: no pops. rf_we and mt_clear are 0 next cycle; victim holds its value.
- rob_head wrap is handled externally; indexing is modulo ROB_SIZE.

Decomposition:
- Shared package: rob_entry, map_table_entry, lsq_entry, Victim, control_bits, RobSize; ROB_SIZE/LSQ_SIZE/NUMBER_OF_REGISTERS defines.
- Add retire_state_t enum {RUN, STORE_WAIT, HALTED} to the package.
- One sub-module is natural: retire_store_handshake, the STORE_WAIT req/ack FSM.

Test Plan:
- ADD x5 retiring: rob_count=1, head=2, ready, rd=5, value=0x2A, map_table[5].tag=3 -> rob_pop=1 that cycle; next cycle rf_we=1, waddr=5, wdata=0x2A, mt_clear=1 for reg 5, victim={5,0x2A}, retired_count=1.
- Same retire with map_table[5].tag=7 (younger rename) -> rf_we=1, mt_clear=0.
- Store at head, store_ack after 3 cycles -> no pop for 3 cycles with store_req=1; on the ack cycle rob_pop=lsq_pop=1; store_req=0 next cycle.
- Ecall at head, a ready ADD behind it -> ecall pops; halt=1; the ADD never pops; store_ack pulses are ignored.
- rd=0 ADDI ready -> rob_pop=1, rf_we=0, victim={0,0}, count increments.
- reset=0 during STORE_WAIT -> next cycle state=RUN, store_req=0, all outputs 0.
